exec_mem_arbiter: RTL and testbench
===================================

// Module: exec_mem_arbiter
//
// PURPOSE
//  Round-robin arbiter sharing the single execute->memory slot among the 4 execution units.
//  Each unit holds its result until granted, using valid/ready handshakes.
//  The winner is captured in a one-entry output register that feeds the memory stage.
//  flush_i (mispredict/exception) discards the buffered result.
//
// PARAMETERS
//  ROBsize      32                    ROB entries
//  ROBsizeLog   $clog2(ROBsize+1)     tag width
//  STARVE_LIMIT 8                     wait cycles before forced priority (EXEC_ARB_STARVE_EN only)
//
// PORTS
//  clk_i              in   1         clock, all state on posedge
//  reset_i            in   1         asynchronous, active-low reset
//  flush_i            in   1         sync flush of output register
//  valid_i            in   4         unit k has a result
//  ready_o            in/out: out 4  one-hot grant; unit k transfers when valid_i[k]&ready_o[k]
//  executeVal_i       in   4x64      per-unit result data
//  executeCommands_i  in   4x10      per-unit command bits
//  executeTag_i       in   4xROBsizeLog  per-unit ROB tag
//  executeFlags_i     in   4x4       per-unit flags
//  memValid_o         out  1         output register holds a result
//  memReady_i         in   1         memory stage accepts this cycle
//  dataToMem_o        out  64        registered data
//  commandsToMem_o    out  10        registered commands
//  tagToMem_o         out  ROBsizeLog registered tag
//  flagsToMem_o       out  4         registered flags
//  grantIdx_o         out  2         unit index of current output entry
//
// BEHAVIOUR
//  - Reset (reset_i=0, async): memValid_o=0, all payload outputs=0, grantIdx_o=0, rrPtr=0.
//    Starvation counters are also cleared.
//  - space = ~memValid_o | memReady_i. ready_o is combinational.
//    ready_o = 0 when flush_i=1 or space=0; otherwise one-hot pick of valid_i.
//  - Pick: rotating priority starting at rrPtr (rrPtr, rrPtr+1, ... mod 4). ready_o=0 if valid_i=0.
//  - Transfer on unit k: the next edge loads payload[k] into the output register.
//    It also sets memValid_o=1, grantIdx_o=k and rrPtr=(k+1) mod 4. Latency 1 cycle input->output.
//  - With no transfer and memReady_i=1: memValid_o<=0 and payload holds its value.
//  - With no transfer and memReady_i=0: everything holds (stall; memValid_o stable).
//  - Back-to-back: memReady_i=1 together with a transfer replaces the entry the same edge.
//    Full throughput is 1 result/cycle.
//  - flush_i=1: next edge memValid_o<=0 and rrPtr holds. No grant that cycle; flush wins over memReady_i.
//  - rrPtr advances only on a transfer; wraps 3->0.
//  - valid_i is sticky: a unit must keep valid_i and payload stable until granted.
//    The bench checks this; the RTL does not.
//
// CONFIGURATION
//  EXEC_ARB_STARVE_EN defined: per-unit counter waitCnt[k], saturating at STARVE_LIMIT.
//    - Increments when valid_i[k]&~ready_o[k]&space&~flush_i.
//    - Clears on grant to k or when valid_i[k]=0.
//    - Any unit with waitCnt==STARVE_LIMIT overrides rotation.
//      The lowest such index wins; rrPtr updates as normal.
//  Undefined: pure round-robin, no counters synthesized.
//
// STRUCTURE
//  - exec_arb_pkg: NUM_EXEC=4, DATA_W=64, CMD_W=10, FLAG_W=4, and typedef exec_pkt_t.
//    exec_pkt_t is a struct of data, cmd and flags; the tag stays a separate parameterized field.
//  - Sub-module exec_rr_pick: combinational 4-way rotating-priority one-hot picker.
//    Inputs req[3:0], ptr[1:0]; outputs gnt[3:0], idx[1:0].
//  - Top-level: picker, output register, rrPtr and optional starvation logic.
//
// TESTING
//  1. Reset then valid_i=4'b1111, memReady_i=1 for 4 cycles.
//     -> grantIdx_o sequence 0,1,2,3; memValid_o rises 1 cycle after first grant.
//  2. memValid_o=1, memReady_i=0, valid_i=4'b0100 for 3 cycles.
//     -> ready_o=0, outputs frozen; memReady_i=1 -> ready_o=4'b0100, unit 2 data appears next cycle.
//  3. Tag 5 in output register, flush_i=1 with memReady_i=1 and valid_i=4'b0001.
//     -> ready_o=0, memValid_o=0 next cycle, rrPtr unchanged.
//  4. Only unit 3 valid with executeVal_i[3]=64'hDEAD_BEEF, memReady_i=1.
//     -> ready_o=4'b1000; next cycle dataToMem_o=DEAD_BEEF, grantIdx_o=3; then rrPtr=0.
//  5. Assert reset_i=0 mid-stall with memValid_o=1.
//     -> memValid_o=0 and outputs=0 immediately, without a clock edge.
//  6. (EXEC_ARB_STARVE_EN, STARVE_LIMIT=2) memReady_i toggling, valid_i=4'b1111, units 0/1 re-asserting.
//     -> a unit waiting 2 grant opportunities is granted on the next one.

Source files
------------

// File: rtl/exec_arb_pkg.sv
// Shared widths and the payload struct for the execute->memory arbiter.
// The ROB tag is kept out of exec_pkt_t because its width is a top-level parameter.
package exec_arb_pkg;
  localparam int NUM_EXEC = 4;
  localparam int IDX_W    = 2;
  localparam int DATA_W   = 64;
  localparam int CMD_W    = 10;
  localparam int FLAG_W   = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CMD_W-1:0]  cmd;
    logic [FLAG_W-1:0] flags;
  } exec_pkt_t;
endpackage

// File: rtl/exec_rr_pick.sv
// Combinational 4-way rotating-priority picker: the search starts at ptr and wraps.
// gnt is one-hot (or zero when req is zero); idx is the granted position.
module exec_rr_pick
  import exec_arb_pkg::*;
(
  input  logic [NUM_EXEC-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [NUM_EXEC-1:0] gnt,
  output logic [IDX_W-1:0]    idx
);

  logic             found;
  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_EXEC; i++) begin
      pos = ptr + IDX_W'(i);
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        idx      = pos;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exec_mem_arbiter.sv
// Round-robin arbiter feeding one execute->memory output register from 4 units.
// Optional starvation override is built when EXEC_ARB_STARVE_EN is defined.
module exec_mem_arbiter
  import exec_arb_pkg::*;
#(
  parameter int ROBsize      = 32,
  parameter int ROBsizeLog   = $clog2(ROBsize + 1),
  parameter int STARVE_LIMIT = 8
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 flush_i,
  input  logic [NUM_EXEC-1:0]                  valid_i,
  output logic [NUM_EXEC-1:0]                  ready_o,
  input  logic [NUM_EXEC-1:0][DATA_W-1:0]      executeVal_i,
  input  logic [NUM_EXEC-1:0][CMD_W-1:0]       executeCommands_i,
  input  logic [NUM_EXEC-1:0][ROBsizeLog-1:0]  executeTag_i,
  input  logic [NUM_EXEC-1:0][FLAG_W-1:0]      executeFlags_i,
  output logic                                 memValid_o,
  input  logic                                 memReady_i,
  output logic [DATA_W-1:0]                    dataToMem_o,
  output logic [CMD_W-1:0]                     commandsToMem_o,
  output logic [ROBsizeLog-1:0]                tagToMem_o,
  output logic [FLAG_W-1:0]                    flagsToMem_o,
  output logic [IDX_W-1:0]                     grantIdx_o
);

  // Handshake: unit k transfers on an edge where valid_i[k] & ready_o[k]; the unit
  // holds valid_i and payload until then. memValid_o/memReady_i follow the same rule.

  logic                  space;
  logic [NUM_EXEC-1:0]   rr_gnt;
  logic [IDX_W-1:0]      rr_idx;
  logic [NUM_EXEC-1:0]   pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  transfer;
  logic [IDX_W-1:0]      rr_ptr;
  exec_pkt_t             out_pkt;
  logic [ROBsizeLog-1:0] out_tag;

  if (STARVE_LIMIT < 1) begin : g_starve_limit_must_be_positive
  end

  exec_rr_pick u_pick (
    .req (valid_i),
    .ptr (rr_ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

`ifdef EXEC_ARB_STARVE_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [NUM_EXEC-1:0][WAIT_W-1:0] wait_cnt;
  logic [NUM_EXEC-1:0]             starve;
  logic [NUM_EXEC-1:0]             starve_gnt;
  logic [IDX_W-1:0]                starve_idx;

  // Descending scan so the lowest starving index is the one left standing.
  always_comb begin
    starve     = '0;
    starve_gnt = '0;
    starve_idx = '0;
    for (int k = NUM_EXEC - 1; k >= 0; k--) begin
      starve[k] = valid_i[k] && (wait_cnt[k] == WAIT_W'(STARVE_LIMIT));
      if (starve[k]) begin
        starve_gnt = NUM_EXEC'(1) << k;
        starve_idx = IDX_W'(k);
      end
    end
    pick_gnt = (|starve) ? starve_gnt : rr_gnt;
    pick_idx = (|starve) ? starve_idx : rr_idx;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wait_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_EXEC; k++) begin
        if (!valid_i[k] || ready_o[k])
          wait_cnt[k] <= '0;
        else if (space && !flush_i && (wait_cnt[k] != WAIT_W'(STARVE_LIMIT)))
          wait_cnt[k] <= wait_cnt[k] + WAIT_W'(1);
      end
    end
  end
`else
  assign pick_gnt = rr_gnt;
  assign pick_idx = rr_idx;
`endif

  assign space    = !memValid_o || memReady_i;
  assign ready_o  = (flush_i || !space) ? '0 : pick_gnt;
  assign transfer = |ready_o;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      memValid_o <= 1'b0;
      out_pkt    <= '0;
      out_tag    <= '0;
      grantIdx_o <= '0;
      rr_ptr     <= '0;
    end else if (transfer) begin
      memValid_o    <= 1'b1;
      out_pkt.data  <= executeVal_i[pick_idx];
      out_pkt.cmd   <= executeCommands_i[pick_idx];
      out_pkt.flags <= executeFlags_i[pick_idx];
      out_tag       <= executeTag_i[pick_idx];
      grantIdx_o    <= pick_idx;
      rr_ptr        <= pick_idx + IDX_W'(1);
    end else if (flush_i || memReady_i) begin
      memValid_o <= 1'b0;
    end
  end

  assign dataToMem_o     = out_pkt.data;
  assign commandsToMem_o = out_pkt.cmd;
  assign flagsToMem_o    = out_pkt.flags;
  assign tagToMem_o      = out_tag;

endmodule

// File: tb/tb_exec_mem_arbiter.sv
// Self-checking bench for exec_mem_arbiter: reference model plus expected-entry queue.
// Define EXEC_ARB_STARVE_EN to build both DUT and model with STARVE_LIMIT=2.
module tb_exec_mem_arbiter;
  localparam int TAG_W = 6;
  localparam int ENT_W = 2 + TAG_W + 4 + 10 + 64;
`ifdef EXEC_ARB_STARVE_EN
  localparam int LIM = 2;
`else
  localparam int LIM = 8;
`endif

  logic                  clk_i = 1'b0;
  logic                  reset_i;
  logic                  flush_i;
  logic [3:0]            valid_i;
  logic [3:0]            ready_o;
  logic [3:0][63:0]      exec_val;
  logic [3:0][9:0]       exec_cmd;
  logic [3:0][TAG_W-1:0] exec_tag;
  logic [3:0][3:0]       exec_flg;
  logic                  memValid_o;
  logic                  memReady_i;
  logic [63:0]           dataToMem_o;
  logic [9:0]            commandsToMem_o;
  logic [TAG_W-1:0]      tagToMem_o;
  logic [3:0]            flagsToMem_o;
  logic [1:0]            grantIdx_o;

  exec_mem_arbiter #(.ROBsize(32), .STARVE_LIMIT(LIM)) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .flush_i           (flush_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .executeVal_i      (exec_val),
    .executeCommands_i (exec_cmd),
    .executeTag_i      (exec_tag),
    .executeFlags_i    (exec_flg),
    .memValid_o        (memValid_o),
    .memReady_i        (memReady_i),
    .dataToMem_o       (dataToMem_o),
    .commandsToMem_o   (commandsToMem_o),
    .tagToMem_o        (tagToMem_o),
    .flagsToMem_o      (flagsToMem_o),
    .grantIdx_o        (grantIdx_o)
  );

  always #5 clk_i = ~clk_i;

  // scoreboard and reference model state
  logic [ENT_W-1:0] exp_q[$];
  int               vectors = 0;
  int               errors  = 0;
  logic             m_valid;
  int               m_ptr;
  logic [ENT_W-1:0] m_ent;
  int               m_wait[4];
  logic [3:0]       m_last_gnt;

  function automatic logic [ENT_W-1:0] dut_ent();
    return {grantIdx_o, tagToMem_o, flagsToMem_o, commandsToMem_o, dataToMem_o};
  endfunction

  task automatic new_payload(input int k);
    exec_val[k] = {$urandom, $urandom};
    exec_cmd[k] = 10'($urandom);
    exec_tag[k] = 6'($urandom_range(0, 32));
    exec_flg[k] = 4'($urandom);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 0;
    m_ent   = '0;
    for (int k = 0; k < 4; k++) m_wait[k] = 0;
    exp_q.delete();
  endtask

  // One cycle: drive inputs, check ready_o, clock, check registered outputs.
  task automatic step(input logic [3:0] v, input logic mr, input logic fl);
    logic       space;
    logic       found;
    int         win;
    logic [3:0] exp_rdy;
    logic [ENT_W-1:0] got;
    logic [ENT_W-1:0] want;
    logic       pending;
    valid_i    = v;
    memReady_i = mr;
    flush_i    = fl;
    space = !m_valid || mr;
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < 4; k++)
      if (!found && v[k] && m_wait[k] == LIM) begin found = 1'b1; win = k; end
`ifndef EXEC_ARB_STARVE_EN
    found = 1'b0;
`endif
    for (int i = 0; i < 4; i++)
      if (!found && v[(m_ptr + i) % 4]) begin found = 1'b1; win = (m_ptr + i) % 4; end
    exp_rdy = (fl || !space || !found) ? 4'b0 : (4'b1 << win);
    #1;
    vectors++;
    if (ready_o !== exp_rdy) begin
      errors++;
      $display("FAIL ready_o: got %b expected %b (valid %b memReady %b flush %b)", ready_o, exp_rdy, v, mr, fl);
    end
    for (int k = 0; k < 4; k++) begin
      if (!v[k] || exp_rdy[k]) m_wait[k] = 0;
      else if (space && !fl && m_wait[k] < LIM) m_wait[k]++;
    end
    pending    = 1'b0;
    m_last_gnt = exp_rdy;
    if (exp_rdy != 4'b0) begin
      exp_q.push_back({2'(win), exec_tag[win], exec_flg[win], exec_cmd[win], exec_val[win]});
      m_valid = 1'b1;
      m_ptr   = (win + 1) % 4;
      pending = 1'b1;
    end else if (fl || mr) begin
      m_valid = 1'b0;
    end
    @(posedge clk_i);
    #1;
    vectors++;
    if (memValid_o !== m_valid) begin
      errors++;
      $display("FAIL memValid_o: got %b expected %b", memValid_o, m_valid);
    end
    got = dut_ent();
    if (pending) begin
      want  = exp_q.pop_front();
      m_ent = want;
      new_payload(win);
    end else begin
      want = m_ent;
    end
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL out_entry: got %h expected %h", got, want);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    flush_i = 1'b0;
    valid_i = 4'b0;
    memReady_i = 1'b0;
    for (int k = 0; k < 4; k++) new_payload(k);
    model_reset();
    repeat (2) @(posedge clk_i);
    #3 reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    vectors++;
    if (memValid_o !== 1'b0 || dut_ent() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid %b entry %h expected 0/0", memValid_o, dut_ent());
    end
    vectors++;
    if (ready_o !== 4'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0000", ready_o);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      vectors++;
      if (grantIdx_o !== 2'(i)) begin
        errors++;
        $display("FAIL rr_sequence: got %0d expected %0d", grantIdx_o, i);
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] d2;
    logic [63:0] held;
    held = dataToMem_o;
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b0);
    vectors++;
    if (dataToMem_o !== held || memValid_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: got %h/%b expected %h/1", dataToMem_o, memValid_o, held);
    end
    d2 = exec_val[2];
    step(4'b0100, 1'b1, 1'b0);
    vectors++;
    if (m_last_gnt !== 4'b0100 || dataToMem_o !== d2 || grantIdx_o !== 2'd2) begin
      errors++;
      $display("FAIL stall_release: got data %h idx %0d expected %h idx 2", dataToMem_o, grantIdx_o, d2);
    end
  endtask

  task automatic test_flush();
    exec_tag[0] = 6'd5;
    step(4'b0001, 1'b1, 1'b0);
    vectors++;
    if (tagToMem_o !== 6'd5) begin
      errors++;
      $display("FAIL flush_tag_load: got %0d expected 5", tagToMem_o);
    end
    step(4'b0001, 1'b1, 1'b1);
    vectors++;
    if (memValid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: got %b expected 0", memValid_o);
    end
    step(4'b1111, 1'b1, 1'b0);
    vectors++;
    if (grantIdx_o !== 2'd1) begin
      errors++;
      $display("FAIL flush_ptr_hold: got %0d expected 1", grantIdx_o);
    end
  endtask

  task automatic test_single_unit();
    exec_val[3] = 64'hDEAD_BEEF;
    step(4'b1000, 1'b1, 1'b0);
    vectors++;
    if (dataToMem_o !== 64'hDEAD_BEEF || grantIdx_o !== 2'd3) begin
      errors++;
      $display("FAIL unit3_data: got %h idx %0d expected deadbeef idx 3", dataToMem_o, grantIdx_o);
    end
    step(4'b1111, 1'b1, 1'b0);
    vectors++;
    if (grantIdx_o !== 2'd0) begin
      errors++;
      $display("FAIL ptr_wrap: got %0d expected 0", grantIdx_o);
    end
  endtask

  task automatic test_async_reset();
    step(4'b0000, 1'b0, 1'b0);
    #2 reset_i = 1'b0;
    #1;
    vectors++;
    if (memValid_o !== 1'b0 || dut_ent() !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid %b entry %h expected 0/0", memValid_o, dut_ent());
    end
    model_reset();
    @(posedge clk_i);
    #3 reset_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_starve();
    for (int i = 0; i < 12; i++) step(4'b1111, 1'(i % 2), 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] rv;
    rv = 4'b0;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 4; k++)
        if (!rv[k] && $urandom_range(0, 1) == 1) rv[k] = 1'b1;
      step(rv, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      rv = rv & ~m_last_gnt;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_flush();
    test_single_unit();
    test_async_reset();
    test_starve();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
